// File: rtl/inv_sub_bytes_sched_pkg.sv
// Shared types/constants for inv_sub_bytes_sched: FSM states, widths, counter
// sizing and the inverse S-box table. Option: INV_SUB_SCHED_PIPE_EN.
package inv_sub_bytes_sched_pkg;

  localparam int WORD_W    = 32;
  localparam int BLK_W     = 128;
  localparam int NUM_WORDS = 4;

`ifdef INV_SUB_SCHED_PIPE_EN
  localparam int LATENCY = 5;
  localparam int CNT_W   = 3;
`else
  localparam int LATENCY = 4;
  localparam int CNT_W   = 2;
`endif

  // Counter value on the last RUN cycle.
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(LATENCY - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  // Entry 0 sits in the top byte.
  localparam logic [2047:0] INV_SBOX = {
    128'h52096ad53036a538bf40a39e81f3d7fb,
    128'h7ce339829b2fff87348e4344c4dee9cb,
    128'h547b9432a6c2233dee4c950b42fac34e,
    128'h082ea16628d924b2765ba2496d8bd125,
    128'h72f8f66486689816d4a45ccc5d65b692,
    128'h6c704850fdedb9da5e154657a78d9d84,
    128'h90d8ab008cbcd30af7e45805b8b34506,
    128'hd02c1e8fca3f0f02c1afbd0301138a6b,
    128'h3a9111414f67dcea97f2cfcef0b4e673,
    128'h96ac7422e7ad3585e2f937e81c75df6e,
    128'h47f11a711d29c5896fb7620eaa18be1b,
    128'hfc563e4bc6d279209adbc0fe78cd5af4,
    128'h1fdda8338807c731b11210592780ec5f,
    128'h60517fa919b54a0d2de57a9f93c99cef,
    128'ha0e03b4dae2af5b0c8ebbb3c83539961,
    128'h172b047eba77d626e169146355210c7d
  };

  function automatic logic [7:0] inv_sbox(
    input logic [7:0] b
  );
    logic [10:0] idx;
    idx = {b, 3'b000};
    return INV_SBOX[11'd2047 - idx -: 8];
  endfunction

endpackage

// File: rtl/inv_sub_bytes_sched_four.sv
// inverse_sub_bytes_four: InvSubBytes on one 32-bit column word.
// Ports: data_in/data_out word, sub_round_in/sub_round_out passthrough flag.
module inverse_sub_bytes_four
  import inv_sub_bytes_sched_pkg::*;
(
  input  logic [WORD_W-1:0] data_in,
  input  logic              sub_round_in,
  output logic [WORD_W-1:0] data_out,
  output logic              sub_round_out
);

  for (genvar g = 0; g < 4; g++) begin : g_byte
    assign data_out[8*g +: 8] =
      inv_sbox(data_in[8*g +: 8]);
  end

  assign sub_round_out = sub_round_in;

endmodule

// File: rtl/inv_sub_bytes_sched.sv
// Two-port round-robin scheduler sharing one InvSubBytes column unit.
// Ports: req0/req1 valid-ready-data in, out valid-ready-data-id, busy.
// Option INV_SUB_SCHED_PIPE_EN registers the S-box output (latency 5).
module inv_sub_bytes_sched
  import inv_sub_bytes_sched_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  input  logic [BLK_W-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [BLK_W-1:0] req1_data,
  output logic             req1_ready,
  output logic             out_valid,
  output logic [BLK_W-1:0] out_data,
  output logic             out_id,
  input  logic             out_ready,
  output logic             busy
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [CNT_W-1:0]  r_cnt;
  logic [BLK_W-1:0]  r_src;
  logic [BLK_W-1:0]  r_res;
  logic              r_id;
  logic              r_last;

  logic              w_idle;
  logic              w_run;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_acc;
  logic              w_xfer;
  logic              w_cnt_last;
  logic [WORD_W-1:0] w_word_in;
  logic [WORD_W-1:0] w_word_out;
  logic [WORD_W-1:0] w_wr_data;
  logic [1:0]        w_wr_idx;
  logic              w_wr_en;

  assign w_idle = (r_state == ST_IDLE);
  assign w_run  = (r_state == ST_RUN);

  // r_last == 1 means port 1 was served last,
  // so port 0 wins a tie.
  assign w_gnt0 = req0_valid &
                  (~req1_valid | r_last);
  assign w_gnt1 = req1_valid &
                  (~req0_valid | ~r_last);

  assign req0_ready = rst_n & w_idle & w_gnt0;
  assign req1_ready = rst_n & w_idle & w_gnt1;
  assign w_acc      = req0_ready | req1_ready;

  assign out_valid  = (r_state == ST_DONE);
  assign w_xfer     = out_valid & out_ready;
  assign out_data   = r_res;
  assign out_id     = r_id;
  assign busy       = ~w_idle;

  assign w_cnt_last = (r_cnt == CNT_LAST);

  always_comb begin
    w_word_in = r_src[127:96];
    unique case (r_cnt[1:0])
      2'd0: w_word_in = r_src[127:96];
      2'd1: w_word_in = r_src[95:64];
      2'd2: w_word_in = r_src[63:32];
      2'd3: w_word_in = r_src[31:0];
      default: w_word_in = r_src[127:96];
    endcase
  end

  inverse_sub_bytes_four u_sbox (
    .data_in       (w_word_in),
    .sub_round_in  (1'b0),
    .data_out      (w_word_out),
    .sub_round_out ()
  );

`ifdef INV_SUB_SCHED_PIPE_EN
  logic [WORD_W-1:0] r_pipe;

  // Word k is issued at count k and lands
  // at count k+1; count 4 wraps idx to 3.
  assign w_wr_data = r_pipe;
  assign w_wr_idx  = r_cnt[1:0] - 2'd1;
  assign w_wr_en   = (r_cnt != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pipe <= '0;
    end else if (w_run) begin
      r_pipe <= w_word_out;
    end
  end
`else
  assign w_wr_data = w_word_out;
  assign w_wr_idx  = r_cnt;
  assign w_wr_en   = 1'b1;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_acc)      w_state_nxt = ST_RUN;
      ST_RUN:  if (w_cnt_last) w_state_nxt = ST_DONE;
      ST_DONE: if (out_ready)  w_state_nxt = ST_IDLE;
      default:                 w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt  <= '0;
      r_src  <= '0;
      r_res  <= '0;
      r_id   <= 1'b0;
      r_last <= 1'b1;
    end else begin
      if (w_acc) begin
        r_src <= w_gnt1 ? req1_data : req0_data;
        r_id  <= w_gnt1;
        r_cnt <= '0;
      end
      if (w_run) begin
        if (!w_cnt_last) begin
          r_cnt <= r_cnt + 1'b1;
        end
        if (w_wr_en) begin
          unique case (w_wr_idx)
            2'd0: r_res[127:96] <= w_wr_data;
            2'd1: r_res[95:64]  <= w_wr_data;
            2'd2: r_res[63:32]  <= w_wr_data;
            2'd3: r_res[31:0]   <= w_wr_data;
            default: ;
          endcase
        end
      end
      if (w_xfer) begin
        r_last <= r_id;
      end
    end
  end

endmodule

// File: tb/tb_inv_sub_bytes_sched.sv
// Directed bench for inv_sub_bytes_sched: results, latency, round-robin,
// stall, reset abort and slice ordering. Honors INV_SUB_SCHED_PIPE_EN.
module tb_inv_sub_bytes_sched;

`ifdef INV_SUB_SCHED_PIPE_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 4;
`endif

  localparam logic [127:0] V63  = {16{8'h63}};
  localparam logic [127:0] V52  = {16{8'h52}};
  localparam logic [127:0] VALT = {8{16'h7c16}};
  localparam logic [127:0] EALT = {8{16'h01ff}};
  localparam logic [127:0] VORD =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] EORD =
    128'h52096ad53036a538bf40a39e81f3d7fb;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         req0_valid;
  logic [127:0] req0_data;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic         req1_ready;
  logic         out_valid;
  logic [127:0] out_data;
  logic         out_id;
  logic         out_ready;
  logic         busy;

  int n_err = 0;
  int n_chk = 0;

  inv_sub_bytes_sched dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_id     (out_id),
    .out_ready  (out_ready),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(
    input string        tag,
    input logic [127:0] got,
    input logic [127:0] exp
  );
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h",
               tag, got, exp);
    end
  endtask

  // Offer a block and return #1 after the
  // accepting edge with valid dropped.
  task automatic offer(
    input bit           port,
    input logic [127:0] d
  );
    int n;
    if (port) begin
      req1_valid = 1'b1;
      req1_data  = d;
    end else begin
      req0_valid = 1'b1;
      req0_data  = d;
    end
    #1;
    n = 0;
    while (!(port ? req1_ready : req0_ready)
           && n < 20) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (n >= 20) check("accept_timeout", 1, 0);
    @(posedge clk);
    #1;
    if (port) req1_valid = 1'b0;
    else      req0_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 20) begin
      @(posedge clk);
      #1;
      cyc++;
    end
  endtask

  task automatic run_one(
    input string        tag,
    input bit           port,
    input logic [127:0] d,
    input logic [127:0] exp
  );
    int c;
    offer(port, d);
    wait_valid(c);
    check({tag, "_lat"},  c, LAT);
    check({tag, "_data"}, out_data, exp);
    check({tag, "_id"},   out_id, port);
    @(posedge clk);
    #1;
    check({tag, "_idle"},
          {out_valid, busy}, 2'b00);
  endtask

  initial begin
    int c;
    rst_n      = 1'b0;
    out_ready  = 1'b1;
    req0_valid = 1'b1;
    req0_data  = V63;
    req1_valid = 1'b1;
    req1_data  = '0;
    #12;
    check("rst_valid", out_valid, 0);
    check("rst_data",  out_data, 0);
    check("rst_id",    out_id, 0);
    check("rst_busy",  busy, 0);
    check("rst_ready",
          {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);

    run_one("p0_63",  0, V63,  '0);
    run_one("p1_00",  1, '0,   V52);
    run_one("p1_alt", 1, VALT, EALT);

    // Both ports valid; last served is 1.
    req0_valid = 1'b1;
    req0_data  = V63;
    req1_valid = 1'b1;
    req1_data  = '0;
    for (int k = 0; k < 4; k++) begin
      int n;
      #1;
      n = 0;
      while (!(req0_ready | req1_ready)
             && n < 20) begin
        @(posedge clk);
        #1;
        n++;
      end
      check("rr_grant",
            {req1_ready, req0_ready},
            (k % 2) ? 2'b10 : 2'b01);
      @(posedge clk);
      #1;
      wait_valid(c);
      check("rr_id", out_id, k % 2);
      check("rr_data", out_data,
            (k % 2) ? V52 : 128'h0);
      @(posedge clk);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(negedge clk);

    // Stall in DONE with a competing request.
    out_ready = 1'b0;
    offer(0, '0);
    wait_valid(c);
    req1_valid = 1'b1;
    req1_data  = VALT;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, V52);
      check("stall_ready",
            {req1_ready, req0_ready}, 2'b00);
    end
    out_ready  = 1'b1;
    req1_valid = 1'b0;
    @(posedge clk);
    #1;
    check("stall_xfer",
          {out_valid, busy}, 2'b00);
    @(negedge clk);

    // Abort a port-1 block at cnt == 2.
    offer(1, VALT);
    @(posedge clk);
    @(posedge clk);
    #1;
    req0_valid = 1'b1;
    req0_data  = V63;
    rst_n      = 1'b0;
    #1;
    check("abort_valid", out_valid, 0);
    check("abort_data",  out_data, 0);
    check("abort_id",    out_id, 0);
    check("abort_busy",  busy, 0);
    check("abort_ready",
          {req1_ready, req0_ready}, 2'b00);
    @(negedge clk);
    req0_valid = 1'b0;
    rst_n      = 1'b1;
    @(negedge clk);

    run_one("order", 0, VORD, EORD);

    $display("Result: errors=%0d of %0d checks",
             n_err, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog");
    $fatal(1, "timeout");
  end

endmodule
